micro_run_ctrl: RTL and testbench
=================================

Name: micro_run_ctrl

Overview:
Run/halt/single-step/breakpoint controller that sequences the 8-bit `micro` core.
- Drives a clock-enable `ce` that gates every state register in the micro: pc, w, a, b, d and is_zero.
- Watches the micro's pc (and optionally is_zero) to stop execution before a chosen instruction.
- Counts executed instructions for the debug console.

Parameters:
PC_WIDTH, 8, width of pc and bp_addr
STEP_WIDTH, 8, width of step_n and the internal remaining-step counter
CNT_WIDTH, 16, width of the executed-instruction counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
run  input  1  1-cycle pulse: start free-running
halt  input  1  1-cycle pulse: stop
step  input  1  1-cycle pulse: execute step_n instructions, then halt
step_n  input  STEP_WIDTH  instruction count for step; 0 is treated as 1
bp_en  input  1  breakpoint enable
bp_addr  input  PC_WIDTH  breakpoint address
pc  input  PC_WIDTH  current micro pc
is_zero  input  1  micro zero flag; used only with MICRO_ZERO_BREAK_EN
cnt_clr  input  1  synchronous clear of cycles
ce  output  1  micro clock enable; the micro advances on a rising clk edge where ce=1
state  output  2  0=HALTED, 1=RUNNING, 2=STEP, 3=BREAK
break_hit  output  1  1 while in BREAK
cycles  output  CNT_WIDTH  count of edges with ce=1, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-run):
  - state=HALTED, ce=0, break_hit=0, cycles=0.
  - remaining counter=0, resume flag=0.
- Command priority within one cycle: halt > step > run. Commands are sampled on the rising edge only.
- Transitions:
  - HALTED: step -> STEP and load remaining = (step_n==0 ? 1 : step_n). run -> RUNNING. Otherwise stay.
  - RUNNING: halt -> HALTED. A gated cycle (see below) -> BREAK.
  - STEP:
    - halt -> HALTED.
    - On each edge with ce=1, remaining decrements; the edge where remaining==1 goes to HALTED.
    - A gated cycle -> BREAK, and remaining is kept.
  - BREAK: halt -> HALTED. step -> STEP with a fresh load. run -> RUNNING.
- resume flag:
  - Set on any transition into RUNNING or STEP.
  - Cleared on the first edge with ce=1 after that.
- bp_match = bp_en && (pc == bp_addr) && !resume.
- ce = (state==RUNNING || state==STEP) && !bp_match.
  - Purely combinational from the state register, pc and the flags.
  - No combinational path from run, halt or step to ce.
- Gated cycle: RUNNING/STEP with bp_match=1. ce=0, so the micro stops before executing the instruction at bp_addr; the next state is BREAK.
- Resuming from BREAK executes the instruction at bp_addr once, because resume masks the match on that first cycle.
- Halt latency: a halt sampled on edge k means the micro advanced on edge k if ce was 1 then; ce=0 from edge k onward.
- break_hit = (state==BREAK), registered with the state.
- cycles:
  - +1 on every edge with ce=1, saturating at all-ones (no wrap).
  - cnt_clr forces 0 and wins over a simultaneous increment.
- Step with bp at the current pc: the first instruction executes (resume); a later match goes to BREAK.
- bp_en toggling mid-run takes effect the same cycle (combinational).

Optional Feature:
MICRO_ZERO_BREAK_EN
- Defined:
  - bp_match additionally includes (state==RUNNING && is_zero && !resume).
  - Free-running stops before the next instruction once the micro's zero flag is set. STEP mode is unaffected.
- Undefined: is_zero is ignored and the logic is removed. The port remains so instantiations are unchanged.

Test Plan:
- Reset, then step=1 with step_n=3 -> ce=1 for exactly 3 edges; state 2 then 0; cycles=3; micro pc advances 3.
- bp_en=1, bp_addr=05, run from pc=00 -> ce falls combinationally when pc=05; state=3; break_hit=1; micro pc holds at 05; cycles=5.
- From BREAK at 05, step with step_n=1 -> the instruction at 05 executes; pc=06; state=0.
- run, then halt and step pulsed in the same cycle -> state=0; remaining unchanged.
- Drive cycles to FFFF while running -> it holds at FFFF. cnt_clr together with ce=1 -> 0000.
- Assert reset mid-STEP -> ce=0 and state=0 before the next edge; break_hit=0. With MICRO_ZERO_BREAK_EN defined: running until is_zero=1 -> state=3 and ce=0.

Source files
------------

// File: rtl/micro_run_ctrl.sv
// micro_run_ctrl
//   Run / halt / single-step / breakpoint sequencer for the 8-bit micro core.
//   Produces the clock enable that gates every micro state register, stops
//   the micro before the instruction at a breakpoint address, and counts the
//   edges on which the micro advanced.
//
// Optional feature macro: MICRO_ZERO_BREAK_EN
//   When defined, free-running (RUNNING) also stops before the next
//   instruction once the micro's zero flag is set. When undefined, is_zero
//   is ignored and the port is kept only for instantiation compatibility.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   run       in   1-cycle pulse, start free-running
//   halt      in   1-cycle pulse, stop (highest priority)
//   step      in   1-cycle pulse, execute step_n instructions then halt
//   step_n    in   instruction count for step (0 behaves as 1)
//   bp_en     in   breakpoint enable
//   bp_addr   in   breakpoint address
//   pc        in   current micro pc
//   is_zero   in   micro zero flag (MICRO_ZERO_BREAK_EN only)
//   cnt_clr   in   synchronous clear of cycles
//   ce        out  micro clock enable
//   state     out  0=HALTED 1=RUNNING 2=STEP 3=BREAK
//   break_hit out  high while in BREAK
//   cycles    out  saturating count of edges with ce=1
module micro_run_ctrl #(
   parameter int PC_WIDTH   = 8,
   parameter int STEP_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  halt,
   input  logic                  step,
   input  logic [STEP_WIDTH-1:0] step_n,
   input  logic                  bp_en,
   input  logic [PC_WIDTH-1:0]   bp_addr,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  is_zero,
   input  logic                  cnt_clr,
   output logic                  ce,
   output logic [1:0]            state,
   output logic                  break_hit,
   output logic [CNT_WIDTH-1:0]  cycles
);

   typedef enum logic [1:0] {
      S_HALTED  = 2'd0,
      S_RUNNING = 2'd1,
      S_STEP    = 2'd2,
      S_BREAK   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [STEP_WIDTH-1:0] rem_q, rem_d;
   logic                  resume_q, resume_d;
   logic                  break_q;
   logic [CNT_WIDTH-1:0]  cyc_q;

   logic                  zero_match;
   logic                  bp_match;
   logic                  active;
   logic                  ce_i;
   logic [STEP_WIDTH-1:0] step_load;

`ifdef MICRO_ZERO_BREAK_EN
   assign zero_match = (state_q == S_RUNNING) && is_zero && !resume_q;
`else
   logic unused_is_zero;
   assign unused_is_zero = is_zero;
   assign zero_match     = 1'b0;
`endif

   // resume masks the match for the first instruction after (re)starting,
   // so the instruction sitting at bp_addr executes exactly once.
   assign bp_match  = (bp_en && (pc == bp_addr) && !resume_q) || zero_match;
   assign active    = (state_q == S_RUNNING) || (state_q == S_STEP);
   assign ce_i      = active && !bp_match;
   assign step_load = (step_n == '0) ? STEP_WIDTH'(1) : step_n;

   // Next-state logic. Commands are only honoured when idle (HALTED/BREAK),
   // except halt which always wins.
   always_comb begin
      state_d  = state_q;
      rem_d    = ce_i ? rem_q - STEP_WIDTH'(1) : rem_q;
      resume_d = ce_i ? 1'b0 : resume_q;
      case (state_q)
         S_HALTED, S_BREAK: begin
            if (halt) begin
               state_d = S_HALTED;
            end else if (step) begin
               state_d  = S_STEP;
               rem_d    = step_load;
               resume_d = 1'b1;
            end else if (run) begin
               state_d  = S_RUNNING;
               resume_d = 1'b1;
            end
         end
         S_RUNNING: begin
            if (halt)          state_d = S_HALTED;
            else if (bp_match) state_d = S_BREAK;
         end
         S_STEP: begin
            // gated cycle keeps rem_q (ce_i=0, so no decrement)
            if (halt)                                   state_d = S_HALTED;
            else if (ce_i && rem_q == STEP_WIDTH'(1))   state_d = S_HALTED;
            else if (bp_match)                          state_d = S_BREAK;
         end
         default: state_d = S_HALTED;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_HALTED;
         rem_q    <= '0;
         resume_q <= 1'b0;
         break_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         resume_q <= resume_d;
         break_q  <= (state_d == S_BREAK);
      end
   end

   // Saturating executed-edge counter; clear beats increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                cyc_q <= '0;
      else if (cnt_clr)         cyc_q <= '0;
      else if (ce_i && ~&cyc_q) cyc_q <= cyc_q + CNT_WIDTH'(1);
   end

   assign ce        = ce_i;
   assign state     = state_q;
   assign break_hit = break_q;
   assign cycles    = cyc_q;

endmodule

// File: tb/tb_micro_run_ctrl.sv
// Bench for micro_run_ctrl: directed command sequences driving a tiny
// micro stand-in (pc increments on every ce edge, loadable by the bench),
// a behavioural model tracked as "free-run / step budget / stopped at
// breakpoint", a per-cycle compare, and hand-computed literal expectations.
module tb_micro_run_ctrl;

   logic        clk, reset;
   logic        run, halt, step, bp_en, is_zero, cnt_clr;
   logic [7:0]  step_n, bp_addr, pc;
   logic        ce, break_hit;
   logic [1:0]  state;
   logic [15:0] cycles;

   logic        pc_ld;
   logic [7:0]  pc_val;

   int n_chk = 0;
   int n_err = 0;

   micro_run_ctrl #(.PC_WIDTH(8), .STEP_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .run(run), .halt(halt), .step(step),
      .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .is_zero(is_zero), .cnt_clr(cnt_clr), .ce(ce), .state(state),
      .break_hit(break_hit), .cycles(cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // micro stand-in
   always @(posedge clk or posedge reset) begin
      if (reset)      pc <= 8'h00;
      else if (pc_ld) pc <= pc_val;
      else if (ce)    pc <= pc + 8'h01;
   end

   // ---------------- behavioural model ----------------
   bit m_free;    // free-running requested
   int m_budget;  // instructions still to execute in step mode
   bit m_brk;     // parked at a breakpoint
   bit m_masked;  // first instruction after a start is not checked
   int m_cyc;
   bit mdl_adv;

   function automatic bit m_active();
      return (m_free || m_budget > 0) && !m_brk;
   endfunction

   function automatic bit m_stop_here();
      bit s;
      s = bp_en && (pc == bp_addr) && !m_masked;
`ifdef MICRO_ZERO_BREAK_EN
      s = s || (m_free && is_zero && !m_masked);
`endif
      return s;
   endfunction

   function automatic bit m_ce();
      return m_active() && !m_stop_here();
   endfunction

   function automatic int m_state();
      if (m_brk)           return 3;
      else if (m_free)     return 1;
      else if (m_budget>0) return 2;
      else                 return 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_free <= 0; m_budget <= 0; m_brk <= 0; m_masked <= 0; m_cyc <= 0;
      end else begin
         mdl_adv = m_ce();
         if (cnt_clr)                     m_cyc <= 0;
         else if (mdl_adv && m_cyc < 65535) m_cyc <= m_cyc + 1;
         if (mdl_adv) m_masked <= 0;
         if (halt) begin
            m_free <= 0; m_budget <= 0; m_brk <= 0;
         end else if (!m_active()) begin
            if (step) begin
               m_budget <= (step_n == 0) ? 1 : int'(step_n);
               m_free <= 0; m_brk <= 0; m_masked <= 1;
            end else if (run) begin
               m_free <= 1; m_budget <= 0; m_brk <= 0; m_masked <= 1;
            end
         end else if (mdl_adv) begin
            if (!m_free) m_budget <= m_budget - 1;
         end else begin
            m_brk <= 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // per-cycle compare, away from the active edge
   always @(negedge clk) begin
      if (!reset) begin
         chk("state", int'(state), m_state());
         chk("ce", int'(ce), int'(m_ce()));
         chk("break_hit", int'(break_hit), int'(m_state() == 3));
         chk("cycles", int'(cycles), m_cyc);
      end
   end

   // inputs change 3 time units after each rising edge
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic pulse_run();  run = 1;  tick(); run = 0;  endtask
   task automatic pulse_halt(); halt = 1; tick(); halt = 0; endtask
   task automatic pulse_step(input logic [7:0] n);
      step_n = n; step = 1; tick(); step = 0;
   endtask
   task automatic load_pc(input logic [7:0] v);
      pc_val = v; pc_ld = 1; cnt_clr = 1; tick(); pc_ld = 0; cnt_clr = 0;
   endtask

   initial begin
      reset = 1; run = 0; halt = 0; step = 0; step_n = 0; bp_en = 0;
      bp_addr = 0; is_zero = 0; cnt_clr = 0; pc_ld = 0; pc_val = 0;
      repeat (2) @(posedge clk);
      #3 reset = 0;

      chk("rst_state", int'(state), 0);
      chk("rst_ce", int'(ce), 0);
      chk("rst_break", int'(break_hit), 0);
      chk("rst_cycles", int'(cycles), 0);

      // step 3 from reset
      pulse_step(8'd3);
      chk("step3_state_mid", int'(state), 2);
      repeat (5) tick();
      chk("step3_state", int'(state), 0);
      chk("step3_cycles", int'(cycles), 3);
      chk("step3_pc", int'(pc), 3);

      // breakpoint at 05, run from 00
      load_pc(8'h00);
      bp_en = 1; bp_addr = 8'h05;
      pulse_run();
      repeat (10) tick();
      chk("bp_state", int'(state), 3);
      chk("bp_hit", int'(break_hit), 1);
      chk("bp_pc", int'(pc), 5);
      chk("bp_cycles", int'(cycles), 5);
      chk("bp_ce", int'(ce), 0);

      // step 1 from BREAK executes the instruction at 05
      pulse_step(8'd1);
      repeat (3) tick();
      chk("resume_pc", int'(pc), 6);
      chk("resume_state", int'(state), 0);
      chk("resume_cycles", int'(cycles), 6);

      // halt and step in the same cycle while running
      pulse_run();
      repeat (3) tick();
      halt = 1; step = 1; step_n = 8'd7; tick(); halt = 0; step = 0;
      repeat (3) tick();
      chk("halt_step_state", int'(state), 0);

      // saturation, then clear with ce=1
      bp_en = 0;
      cnt_clr = 1; tick(); cnt_clr = 0;
      pulse_run();
      repeat (65540) tick();
      chk("sat_cycles", int'(cycles), 16'hFFFF);
      chk("sat_state", int'(state), 1);
      cnt_clr = 1; tick(); cnt_clr = 0;
      chk("clr_cycles", int'(cycles), 0);
      pulse_halt();

      // step 5 from pc 08 with bp at 0A: breaks before 0A
      load_pc(8'h08);
      bp_en = 1; bp_addr = 8'h0A;
      pulse_step(8'd5);
      repeat (6) tick();
      chk("step_bp_state", int'(state), 3);
      chk("step_bp_pc", int'(pc), 8'h0A);
      // step_n=0 behaves as 1
      pulse_step(8'd0);
      repeat (4) tick();
      chk("step0_state", int'(state), 0);
      chk("step0_pc", int'(pc), 8'h0B);

      // enabling a breakpoint at the current pc stops ce the same cycle
      bp_en = 0;
      pulse_run();
      repeat (4) tick();
      bp_addr = pc; bp_en = 1;
      #1 chk("bp_toggle_ce", int'(ce), 0);
      tick();
      chk("bp_toggle_state", int'(state), 3);
      pulse_halt();

      // reset in the middle of a step sequence
      bp_en = 0;
      pulse_step(8'd50);
      repeat (3) tick();
      chk("pre_rst_state", int'(state), 2);
      #1 reset = 1;
      #1;
      chk("mid_rst_ce", int'(ce), 0);
      chk("mid_rst_state", int'(state), 0);
      chk("mid_rst_break", int'(break_hit), 0);
      tick();
      reset = 0;

      // zero-flag stop while running
      pulse_run();
      repeat (3) tick();
      is_zero = 1;
`ifdef MICRO_ZERO_BREAK_EN
      #1 chk("zero_ce", int'(ce), 0);
      tick();
      chk("zero_state", int'(state), 3);
`else
      #1 chk("zero_ce", int'(ce), 1);
      tick();
      chk("zero_state", int'(state), 1);
`endif
      pulse_halt();
      // step mode ignores the zero flag
      pulse_step(8'd2);
      repeat (4) tick();
      chk("zero_step_state", int'(state), 0);
      is_zero = 0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
